// File: rtl/rolling_window_feeder.sv
// Sample-history front end for the rolling-average core.
// Keeps the last NUM_ELEM accepted samples in a circular buffer. For each
// accepted sample it presents the new value, the value it evicts and a
// one-cycle update strobe. A flush walks the window back to all-zero.
module rolling_window_feeder #(
    parameter int BITS_PER_ELEM = 5,
    parameter int NUM_ELEM      = 8,
    parameter int ADDR_BITS     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITS_PER_ELEM-1:0] i_sample,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_flush,
    output logic [BITS_PER_ELEM-1:0] o_new,
    output logic [BITS_PER_ELEM-1:0] o_old,
    output logic                     o_start_calc,
    output logic [ADDR_BITS:0]       o_fill_count,
    output logic                     o_full,
    output logic                     o_flushing
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [ADDR_BITS:0] FILL_MAX  = (ADDR_BITS+1)'(NUM_ELEM);
    localparam logic [ADDR_BITS:0] LAST_STEP = (ADDR_BITS+1)'(NUM_ELEM - 1);

    state_t                   state;
    logic [BITS_PER_ELEM-1:0] win_mem [NUM_ELEM];
    logic [ADDR_BITS-1:0]     ptr;
    logic [ADDR_BITS:0]       step;
    logic                     accept;

    // Ready only while running and no flush is being requested.
    always_comb begin
        o_ready = (state == RUN) && !i_flush;
        accept  = i_valid && o_ready;
    end

    // Buffer, pointer, run/flush sequencing and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ELEM; i++) begin
                win_mem[i] <= '0;
            end
            state        <= RUN;
            ptr          <= '0;
            step         <= '0;
            o_new        <= '0;
            o_old        <= '0;
            o_start_calc <= 1'b0;
            o_fill_count <= '0;
            o_full       <= 1'b0;
            o_flushing   <= 1'b0;
        end else begin
            o_start_calc <= 1'b0;
            case (state)
                RUN: begin
                    if (i_flush) begin
                        state        <= FLUSH;
                        step         <= '0;
                        o_fill_count <= '0;
                        o_full       <= 1'b0;
                        o_flushing   <= 1'b1;
                    end else if (accept) begin
                        o_new        <= i_sample;
                        o_old        <= win_mem[ptr];
                        win_mem[ptr] <= i_sample;
                        ptr          <= ptr + 1'b1;
                        o_start_calc <= 1'b1;
                        if (o_fill_count != FILL_MAX) begin
                            o_fill_count <= o_fill_count + 1'b1;
                            o_full       <= (o_fill_count == LAST_STEP);
                        end
                    end
                end
                FLUSH: begin
                    // Every slot is stepped, zero or not, so the averager
                    // sees exactly NUM_ELEM subtractions.
                    o_new        <= '0;
                    o_old        <= win_mem[ptr];
                    win_mem[ptr] <= '0;
                    ptr          <= ptr + 1'b1;
                    o_start_calc <= 1'b1;
                    step         <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        state      <= RUN;
                        o_flushing <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rolling_window_feeder.sv
// Directed self-checking bench for rolling_window_feeder.
module tb_rolling_window_feeder;

    logic       clk;
    logic       rst;
    logic [4:0] i_sample;
    logic       i_valid;
    logic       o_ready;
    logic       i_flush;
    logic [4:0] o_new;
    logic [4:0] o_old;
    logic       o_start_calc;
    logic [3:0] o_fill_count;
    logic       o_full;
    logic       o_flushing;

    int errors = 0;
    int checks = 0;

    rolling_window_feeder #(
        .BITS_PER_ELEM(5),
        .NUM_ELEM     (8),
        .ADDR_BITS    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sample    (i_sample),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_flush     (i_flush),
        .o_new       (o_new),
        .o_old       (o_old),
        .o_start_calc(o_start_calc),
        .o_fill_count(o_fill_count),
        .o_full      (o_full),
        .o_flushing  (o_flushing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_new"},   32'(o_new), 0);
        chk({tag, "_old"},   32'(o_old), 0);
        chk({tag, "_start"}, 32'(o_start_calc), 0);
        chk({tag, "_count"}, 32'(o_fill_count), 0);
        chk({tag, "_full"},  32'(o_full), 0);
        chk({tag, "_flush"}, 32'(o_flushing), 0);
    endtask

    // Oldest-first window contents after fill 1..8 then accepts 20, 21.
    int flush_old [8] = '{3, 4, 5, 6, 7, 8, 20, 21};

    initial begin
        rst      = 1'b0;
        i_sample = '0;
        i_valid  = 1'b0;
        i_flush  = 1'b0;

        // Reset takes effect with no clock edge (first rising edge is at t=5).
        #1 rst = 1'b1;
        #1;
        chk_cleared("reset_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_ready", 32'(o_ready), 1);
        chk("rel_count", 32'(o_fill_count), 0);

        // Fill with 1..8 back to back.
        for (int v = 1; v <= 8; v++) begin
            i_valid  = 1'b1;
            i_sample = 5'(v);
            chk("fill_ready", 32'(o_ready), 1);
            tick();
            chk("fill_start", 32'(o_start_calc), 1);
            chk("fill_new",   32'(o_new), 32'(v));
            chk("fill_old",   32'(o_old), 0);
            chk("fill_count", 32'(o_fill_count), 32'(v));
            chk("fill_full",  32'(o_full), (v == 8) ? 1 : 0);
        end
        i_valid = 1'b0;
        tick();
        chk("idle_start", 32'(o_start_calc), 0);
        chk("idle_new",   32'(o_new), 8);
        chk("idle_count", 32'(o_fill_count), 8);
        chk("idle_full",  32'(o_full), 1);

        // Eviction once the window is full.
        i_valid = 1'b1; i_sample = 5'd20;
        tick();
        chk("evict0_new",   32'(o_new), 20);
        chk("evict0_old",   32'(o_old), 1);
        i_sample = 5'd21;
        tick();
        chk("evict1_new",   32'(o_new), 21);
        chk("evict1_old",   32'(o_old), 2);
        chk("evict1_count", 32'(o_fill_count), 8);
        chk("evict1_start", 32'(o_start_calc), 1);

        // Flush with a competing valid sample 9 held throughout.
        i_valid = 1'b1; i_sample = 5'd9; i_flush = 1'b1;
        #1 chk("prio_ready", 32'(o_ready), 0);
        tick();
        i_flush = 1'b0;
        chk("fl_entry_flushing", 32'(o_flushing), 1);
        chk("fl_entry_count",    32'(o_fill_count), 0);
        chk("fl_entry_full",     32'(o_full), 0);
        chk("fl_entry_start",    32'(o_start_calc), 0);
        chk("fl_entry_new",      32'(o_new), 21);
        chk("fl_entry_ready",    32'(o_ready), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fl_start", 32'(o_start_calc), 1);
            chk("fl_new",   32'(o_new), 0);
            chk("fl_old",   32'(o_old), 32'(flush_old[k]));
            chk("fl_count", 32'(o_fill_count), 0);
            chk("fl_flushing", 32'(o_flushing), (k < 7) ? 1 : 0);
            chk("fl_ready", 32'(o_ready), (k < 7) ? 0 : 1);
        end
        i_valid = 1'b0;
        tick();
        chk("post_fl_start", 32'(o_start_calc), 0);

        // Window is zero after the flush.
        i_valid = 1'b1; i_sample = 5'd5;
        tick();
        i_valid = 1'b0;
        chk("post_fl_new",   32'(o_new), 5);
        chk("post_fl_old",   32'(o_old), 0);
        chk("post_fl_count", 32'(o_fill_count), 1);

        // Async reset during flush step 3; slot holding 5 is not yet flushed.
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (3) tick();
        chk("mid_start", 32'(o_start_calc), 1);
        chk("mid_flushing", 32'(o_flushing), 1);
        #1 rst = 1'b1;
        #1;
        chk_cleared("mid_rst");
        #1 rst = 1'b0;
        chk("mid_rel_ready", 32'(o_ready), 1);

        // Buffer cleared by reset: three accepts reach the slot that held 5.
        for (int v = 7; v <= 9; v++) begin
            i_valid  = 1'b1;
            i_sample = 5'(v);
            tick();
            chk("after_rst_new",   32'(o_new), 32'(v));
            chk("after_rst_old",   32'(o_old), 0);
            chk("after_rst_count", 32'(o_fill_count), 32'(v - 6));
        end
        i_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
